multdiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit serving the execute stage of the pipelined processor, beside the ALU. It generalises the fixed 32-bit signed multdiv in four ways:

- operand width is a parameter;
- signed or unsigned operation is chosen per operation;
- a destination tag travels with the operation so the writeback latch needs no copy of the instruction;
- an in-flight operation can be cancelled on a branch or flush.

Results come back after a fixed, deterministic latency with a one-cycle ready pulse.

---
 rtl/multdiv_iter.sv | 163 ++++++++++++++++
 tb/tb_multdiv_iter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, WIDTH+1 cycle latency.
// Carries a destination tag with each operation and supports cancel on branch/flush.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  input  logic             ctrl_CANCEL,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAG_W-1:0] tag_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 signed_q, signed_d;
  logic                 neg_q, neg_d;
  logic                 bzero_q, bzero_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic [TAG_W-1:0]     tag_out_q, tag_out_d;

  logic start_req, start_ok, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;

  assign start_req = ctrl_MULT | ctrl_DIV;
  assign start_ok  = start_req & ~ctrl_CANCEL & (state_q != RUN);
  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH));

  // State register; all datapath registers share the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      signed_q  <= 1'b0;
      neg_q     <= 1'b0;
      bzero_q   <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      signed_q  <= signed_d;
      neg_q     <= neg_d;
      bzero_q   <= bzero_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      tag_out_q <= tag_out_d;
    end
  end

  // Next-state logic; cancel outranks both completion and a new start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN: begin
        if (ctrl_CANCEL)    state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: state_d = start_ok ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    data_resultRDY = (state_q == DONE);
    busy           = (state_q != IDLE);
    data_exception = exc_q & (state_q == DONE);
  end

  assign data_result = result_q;
  assign tag_out     = tag_out_q;

  // One iteration step of each algorithm and the final sign fix-up.
  always_comb begin
    a_mag     = (ctrl_SIGNED & data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    b_mag     = (ctrl_SIGNED & data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    prod_s    = neg_q ? -acc_q : acc_q;
    quo_s     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    signed_d  = signed_q;
    neg_d     = neg_q;
    bzero_d   = bzero_q;
    tag_d     = tag_q;
    result_d  = result_q;
    exc_d     = exc_q;
    tag_out_d = tag_out_q;
    if (start_ok) begin
      is_div_d = ~ctrl_MULT;
      signed_d = ctrl_SIGNED;
      neg_d    = ctrl_SIGNED & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
      bzero_d  = (data_operandB == '0);
      tag_d    = tag_in;
      cnt_d    = '0;
      opnd_d   = ctrl_MULT ? a_mag : b_mag;
      acc_d    = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
    end else if (state_q == RUN && !ctrl_CANCEL) begin
      if (!last_iter) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q)
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        tag_out_d = tag_q;
        if (is_div_q) begin
          result_d = bzero_q ? '0 : quo_s;
          // Only -2^(W-1) / -1 yields a positive quotient with the top bit set.
          exc_d    = bzero_q | (signed_q & ~neg_q & acc_q[WIDTH-1]);
        end else begin
          result_d = prod_s[WIDTH-1:0];
          exc_d    = signed_q ? (|prod_s[2*WIDTH-1:WIDTH-1]) & ~(&prod_s[2*WIDTH-1:WIDTH-1])
                              : |acc_q[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: 32-bit and 8-bit instances, latency, cancel, async reset.
module tb_multdiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        mult, div, sgn, cancel;
  logic [31:0] opa, opb, res;
  logic [4:0]  tg_in, tg_out;
  logic        exc, rdy, busy;

  logic        m8, d8, s8, c8;
  logic [7:0]  a8, b8, res8;
  logic [4:0]  t8_in, t8_out;
  logic        exc8, rdy8, busy8;

  multdiv_iter #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clock(clk), .reset(rst), .ctrl_MULT(mult), .ctrl_DIV(div), .ctrl_SIGNED(sgn),
    .ctrl_CANCEL(cancel), .data_operandA(opa), .data_operandB(opb), .tag_in(tg_in),
    .data_result(res), .data_exception(exc), .data_resultRDY(rdy), .tag_out(tg_out), .busy(busy)
  );

  multdiv_iter #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clock(clk), .reset(rst), .ctrl_MULT(m8), .ctrl_DIV(d8), .ctrl_SIGNED(s8),
    .ctrl_CANCEL(c8), .data_operandA(a8), .data_operandB(b8), .tag_in(t8_in),
    .data_result(res8), .data_exception(exc8), .data_resultRDY(rdy8), .tag_out(t8_out), .busy(busy8)
  );

  int total  = 0;
  int passed = 0;
  logic [31:0] last_res;
  logic [4:0]  last_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  // Launch one operation on the 32-bit unit and verify latency, ready pulse and result.
  task automatic do_op(input string name, input bit is_div, input bit signed_op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                       input logic [31:0] exp_res, input bit exp_exc);
    logic bad;
    mult = ~is_div; div = is_div; sgn = signed_op; opa = a; opb = b; tg_in = tg;
    @(posedge clk); #1;
    mult = 1'b0; div = 1'b0; opa = $urandom; opb = $urandom; tg_in = 5'($urandom);
    check({name, "_start"}, 64'({busy, rdy}), 64'b10);
    bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (rdy || !busy) bad = 1'b1;
    end
    check({name, "_latency"}, 64'(bad), 64'd0);
    @(posedge clk); #1;
    check({name, "_rdy"}, 64'(rdy), 64'd1);
    check({name, "_res"}, 64'(res), 64'(exp_res));
    check({name, "_exc"}, 64'(exc), 64'(exp_exc));
    check({name, "_tag"}, 64'(tg_out), 64'(tg));
    @(posedge clk); #1;
    check({name, "_after"}, 64'({rdy, busy, exc}), 64'd0);
    last_res = exp_res;
    last_tag = tg;
  endtask

  initial begin
    logic bad;
    rst = 1'b1;
    mult = 0; div = 0; sgn = 0; cancel = 0; opa = '0; opb = '0; tg_in = '0;
    m8 = 0; d8 = 0; s8 = 0; c8 = 0; a8 = '0; b8 = '0; t8_in = '0;
    #1;
    check("reset32", 64'({res, tg_out, exc, rdy, busy}), 64'd0);
    check("reset8", 64'({res8, t8_out, exc8, rdy8, busy8}), 64'd0);
    #11 rst = 1'b0;

    do_op("mul_s_7x-3",   0, 1, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 0);
    do_op("mul_s_ovf",    0, 1, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0000, 1);
    do_op("mul_u_ovf",    0, 0, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000, 1);
    do_op("mul_s_m1xm1",  0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 0);
    do_op("mul_u_max_x2", 0, 0, 32'hFFFF_FFFF, 32'd2,         5'd5, 32'hFFFF_FFFE, 1);
    do_op("mul_s_m1x2",   0, 1, 32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFE, 0);
    do_op("div_s_-7/2",   1, 1, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFD, 0);
    do_op("div_u_big/2",  1, 0, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'h7FFF_FFFC, 0);
    do_op("div_s_100/-7", 1, 1, 32'd100,      32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 0);
    do_op("div_5/0",      1, 0, 32'd5,        32'd0,         5'd10, 32'h0000_0000, 1);
    do_op("div_s_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);

    // Cancel a divide ten edges in, then try a start together with cancel.
    div = 1; sgn = 0; opa = 32'd100; opb = 32'd7; tg_in = 5'd12;
    @(posedge clk); #1;
    div = 0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    mult = 1; cancel = 1; opa = 32'd3; opb = 32'd3; tg_in = 5'd13;
    @(posedge clk); #1;
    mult = 0; cancel = 0;
    check("start_with_cancel", 64'({busy, rdy}), 64'd0);
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rdy || busy) bad = 1'b1;
    end
    check("no_rdy_after_cancel", 64'(bad), 64'd0);
    check("cancel_res_held", 64'(res), 64'(last_res));
    check("cancel_tag_held", 64'(tg_out), 64'(last_tag));

    // Asynchronous reset mid-cycle while running.
    mult = 1; sgn = 0; opa = 32'h1234; opb = 32'h10; tg_in = 5'h1F;
    @(posedge clk); #1;
    mult = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset", 64'({res, tg_out, exc, rdy, busy}), 64'd0);
    @(posedge clk); #1;
    check("reset_held_idle", 64'(busy), 64'd0);
    rst = 1'b0;
    do_op("mul_after_reset", 0, 0, 32'd3, 32'd4, 5'd3, 32'd12, 0);

    // 8-bit unit: overflow multiply, then back-to-back start in the DONE cycle.
    m8 = 1; s8 = 0; a8 = 8'd200; b8 = 8'd2; t8_in = 5'h13;
    @(posedge clk); #1;
    m8 = 0;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy8 || !busy8) bad = 1'b1;
    end
    check("w8_latency", 64'(bad), 64'd0);
    @(posedge clk); #1;
    check("w8_rdy", 64'(rdy8), 64'd1);
    check("w8_res", 64'(res8), 64'h90);
    check("w8_exc", 64'(exc8), 64'd1);
    check("w8_tag", 64'(t8_out), 64'h13);
    m8 = 1; a8 = 8'd3; b8 = 8'd5; t8_in = 5'h07;
    @(posedge clk); #1;
    m8 = 0;
    check("w8_b2b_start", 64'({busy8, rdy8, exc8}), 64'b100);
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy8 || !busy8) bad = 1'b1;
    end
    check("w8_b2b_latency", 64'(bad), 64'd0);
    @(posedge clk); #1;
    check("w8_b2b_rdy", 64'(rdy8), 64'd1);
    check("w8_b2b_res", 64'(res8), 64'd15);
    check("w8_b2b_exc", 64'(exc8), 64'd0);
    check("w8_b2b_tag", 64'(t8_out), 64'h07);
    @(posedge clk); #1;
    check("w8_idle", 64'({rdy8, busy8}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
